// File: rtl/wavetable_voice_reader.sv
// Wavetable oscillator: per tick, reads two adjacent table entries, linearly interpolates, and offers one sample.
// sample_valid rises in the fifth cycle after the tick cycle. Ticks arriving while busy are dropped and flagged by overrun.
module wavetable_voice_reader #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 16,
  parameter int PHASE_W = 24
) (
  input  logic               clk_clk,
  input  logic               reset_reset_n,
  input  logic               enable,
  input  logic               phase_clr,
  input  logic [PHASE_W-1:0] phase_inc,
  input  logic               sample_tick,
  output logic [ADDR_W-1:0]  mem_address,
  output logic               mem_chipselect,
  output logic               mem_clken,
  output logic               mem_write,
  output logic [DATA_W-1:0]  mem_writedata,
  output logic [1:0]         mem_byteenable,
  input  logic [DATA_W-1:0]  mem_readdata,
  output logic [DATA_W-1:0]  sample_data,
  output logic               sample_valid,
  input  logic               sample_ready,
  output logic               overrun
);

  localparam int PW = DATA_W + 9;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD0   = 3'd1,
    RD1   = 3'd2,
    CAP   = 3'd3,
    CALC  = 3'd4,
    VALID = 3'd5
  } state_t;

  state_t state, state_nxt;

  logic [PHASE_W-1:0]       phase;
  logic [ADDR_W-1:0]        idx;
  logic [7:0]               frac;
  logic signed [DATA_W-1:0] s0, s1;
  logic                     tick_acc;

  logic signed [DATA_W:0]   diff;
  logic signed [PW-1:0]     diff_w, frac_w, prod;
  logic [DATA_W-1:0]        interp;

  assign tick_acc = sample_tick && enable && (state == IDLE);

  // Product of a 17-bit difference and an unsigned 8-bit fraction always fits in PW bits.
  assign diff   = $signed({s1[DATA_W-1], s1}) - $signed({s0[DATA_W-1], s0});
  assign diff_w = PW'(diff);
  assign frac_w = PW'($signed({1'b0, frac}));
  assign prod   = diff_w * frac_w;
  assign interp = DATA_W'(PW'(s0) + (prod >>> 8));

  assign mem_write      = 1'b0;
  assign mem_writedata  = '0;
  assign mem_byteenable = 2'b11;
  assign sample_valid   = (state == VALID);

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state       <= IDLE;
      phase       <= '0;
      idx         <= '0;
      frac        <= '0;
      s0          <= '0;
      s1          <= '0;
      sample_data <= '0;
      overrun     <= 1'b0;
    end else begin
      state   <= state_nxt;
      overrun <= sample_tick && enable && (state != IDLE);
      // Clear wins over the increment; an accepted tick still latches the old phase.
      if (phase_clr)
        phase <= '0;
      else if (tick_acc)
        phase <= phase + phase_inc;
      if (tick_acc) begin
        idx  <= phase[PHASE_W-1 -: ADDR_W];
        frac <= phase[PHASE_W-ADDR_W-1 -: 8];
      end
      if (state == RD1)
        s0 <= $signed(mem_readdata);
      if (state == CAP)
        s1 <= $signed(mem_readdata);
      if (state == CALC)
        sample_data <= interp;
    end
  end

  always_comb begin
    state_nxt      = state;
    mem_address    = '0;
    mem_chipselect = 1'b0;
    mem_clken      = 1'b0;
    case (state)
      IDLE: begin
        if (tick_acc)
          state_nxt = RD0;
      end
      RD0: begin
        mem_address    = idx;
        mem_chipselect = 1'b1;
        mem_clken      = 1'b1;
        state_nxt      = RD1;
      end
      RD1: begin
        mem_address    = idx + ADDR_W'(1);
        mem_chipselect = 1'b1;
        mem_clken      = 1'b1;
        state_nxt      = CAP;
      end
      CAP:   state_nxt = CALC;
      CALC:  state_nxt = VALID;
      VALID: begin
        if (sample_ready)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
